// File: rtl/ntt_pkg.sv
// Shared NTT scheduler definitions: FSM encoding and bank-select names.
package ntt_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  localparam logic BANK0 = 1'b0;
  localparam logic BANK1 = 1'b1;

endpackage

// File: rtl/ntt_delay_line.sv
// Valid+data shift register; each stage only loads data behind a valid,
// so the output data holds the last valid payload while out_vld is low.
module ntt_delay_line #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld,
  input  logic [W-1:0] in_data,
  output logic         out_vld,
  output logic [W-1:0] out_data,
  output logic         any_valid
);

  logic [DEPTH-1:0]        vld;
  logic [DEPTH-1:0][W-1:0] dat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      dat <= '0;
    end else begin
      vld[0] <= in_vld;
      if (in_vld) dat[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) dat[i] <= dat[i-1];
      end
    end
  end

  // Pending entries only: the one leaving on the output this cycle is
  // already being issued, so it does not count.
  always_comb begin
    any_valid = in_vld;
    for (int i = 0; i < DEPTH-1; i++) any_valid = any_valid | vld[i];
  end

  assign out_vld  = vld[DEPTH-1];
  assign out_data = dat[DEPTH-1];

endmodule

// File: rtl/ntt_bank_sched.sv
// Radix-2 in-place NTT stage/address scheduler over two ping-pong banks:
// one butterfly read per cycle, matching write BF_LAT+1 cycles later.
module ntt_bank_sched
  import ntt_pkg::*;
#(
  parameter int  N      = 256,
  parameter int  BF_LAT = 4,
  localparam int LOGN   = $clog2(N),
  localparam int D      = BF_LAT + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            hold,
  output logic            busy,
  output logic            done,
  output logic            src_sel,
  output logic [LOGN-1:0] stage,
  output logic            rd_en,
  output logic [LOGN-1:0] rd_addr_a,
  output logic [LOGN-1:0] rd_addr_b,
  output logic [LOGN-2:0] tw_addr,
  output logic            bf_valid,
  output logic            wr_en,
  output logic [LOGN-1:0] wr_addr_a,
  output logic [LOGN-1:0] wr_addr_b
);

  localparam logic [LOGN-2:0] K_LAST     = '1;
  localparam logic [LOGN-1:0] STAGE_LAST = LOGN'(LOGN - 1);

  logic [1:0]      state;
  logic [LOGN-2:0] k;
  logic [LOGN-1:0] kx, half, mask, a_nxt, b_nxt;
  logic [LOGN-2:0] tw_nxt;
  logic            dl_any;

  // a: insert a zero at bit position 'stage' of k; b sets that bit.
  always_comb begin
    kx     = {1'b0, k};
    half   = LOGN'(1) << stage;
    mask   = half - LOGN'(1);
    a_nxt  = ((kx >> stage) << (stage + LOGN'(1))) | (kx & mask);
    b_nxt  = a_nxt | half;
    tw_nxt = (k & mask[LOGN-2:0]) << (STAGE_LAST - stage);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      src_sel   <= BANK0;
      stage     <= '0;
      k         <= '0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr   <= '0;
      bf_valid  <= 1'b0;
    end else begin
      done     <= 1'b0;
      rd_en    <= 1'b0;
      bf_valid <= rd_en;
      case (state)
        S_IDLE: begin
          // busy is still high in the done cycle, which keeps start masked there
          busy <= 1'b0;
          if (start && !busy) begin
            busy    <= 1'b1;
            state   <= S_RUN;
            stage   <= '0;
            k       <= '0;
            src_sel <= BANK0;
          end
        end
        S_RUN: begin
          if (!hold) begin
            rd_en     <= 1'b1;
            rd_addr_a <= a_nxt;
            rd_addr_b <= b_nxt;
            tw_addr   <= tw_nxt;
            k         <= k + 1'b1;
            if (k == K_LAST) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!dl_any) begin
            if (stage == STAGE_LAST) begin
              state <= S_FIN;
            end else begin
              stage   <= stage + 1'b1;
              src_sel <= ~src_sel;
              k       <= '0;
              state   <= S_RUN;
            end
          end
        end
        default: begin
          done    <= 1'b1;
          src_sel <= ~src_sel;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  ntt_delay_line #(.W(2*LOGN), .DEPTH(D)) u_wr_dly (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_vld    (rd_en),
    .in_data   ({rd_addr_a, rd_addr_b}),
    .out_vld   (wr_en),
    .out_data  ({wr_addr_a, wr_addr_b}),
    .any_valid (dl_any)
  );

endmodule

// File: tb/tb_ntt_bank_sched.sv
// Randomized bench for ntt_bank_sched (N=8, BF_LAT=2) against a read-schedule model.
module tb_ntt_bank_sched;

  localparam int N      = 8;
  localparam int BF_LAT = 2;
  localparam int LOGN   = $clog2(N);
  localparam int D      = BF_LAT + 1;
  localparam int HALF_N = N / 2;
  localparam int TOT    = LOGN * HALF_N;

  logic            clk, rst_n, start, hold;
  logic            busy, done, src_sel, rd_en, bf_valid, wr_en;
  logic [LOGN-1:0] stage, rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [LOGN-2:0] tw_addr;

  int n_tests = 0;
  int n_fail  = 0;
  int t;
  int obs_done, n_done;
  int ea [TOT];
  int eb [TOT];
  int etw[TOT];
  int est[TOT];
  int hr [64];
  int ha [64];
  int hb [64];

  ntt_bank_sched #(.N(N), .BF_LAT(BF_LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .hold      (hold),
    .busy      (busy),
    .done      (done),
    .src_sel   (src_sel),
    .stage     (stage),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .tw_addr   (tw_addr),
    .bf_valid  (bf_valid),
    .wr_en     (wr_en),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0d)", tag, got, exp, t);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {busy, done, src_sel, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
              bf_valid, wr_en, wr_addr_a, wr_addr_b}, 0);
  endtask

  // Butterfly order per stage: groups of 2*half, pairs (i, i+half) inside.
  task automatic build_ref();
    int ri = 0;
    for (int s = 0; s < LOGN; s++) begin
      int h = 1 << s;
      for (int g = 0; g < N / (2 * h); g++)
        for (int i = 0; i < h; i++) begin
          ea[ri]  = g * 2 * h + i;
          eb[ri]  = ea[ri] + h;
          etw[ri] = i * (N / (2 * h));
          est[ri] = s;
          ri++;
        end
    end
  endtask

  // Called #1 after a posedge with the DUT idle. abort_at >= 0 pulls reset there.
  task automatic run_xfer(input int hold_pct, input int start_pct,
                          input logic [63:0] hmask, input int abort_at);
    int ri       = 0;
    int earliest = 1;
    int done_cyc = -1;
    int hprev    = 0;
    int e_rd, e_wr, p;
    logic h;
    for (int i = 0; i < 64; i++) begin hr[i] = 0; ha[i] = 0; hb[i] = 0; end
    obs_done = -1;
    n_done   = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      t = c;
      if (c == abort_at) begin
        rst_n = 1'b0;
        hold  = 1'b0;
        #1 chk_zero("rst_async");
        repeat (2) @(posedge clk);
        #1 chk_zero("rst_held");
        rst_n = 1'b1;
        for (int j = 0; j < D + 2; j++) begin
          @(posedge clk); #1;
          chk("wr_after_rst", wr_en, 0);
          chk("busy_after_rst", busy, 0);
        end
        return;
      end
      e_rd = (ri < TOT && c >= earliest && hprev == 0) ? 1 : 0;
      chk("rd_en", rd_en, e_rd);
      if (e_rd != 0) begin
        chk("rd_a", rd_addr_a, ea[ri]);
        chk("rd_b", rd_addr_b, eb[ri]);
        chk("tw", tw_addr, etw[ri]);
        chk("stage", stage, est[ri]);
        chk("src_sel", src_sel, est[ri] % 2);
        if ((ri + 1) % HALF_N == 0) begin
          earliest = c + D + 2;
          if (ri + 1 == TOT) done_cyc = c + D + 2;
        end
        ri++;
      end
      chk("bf_valid", bf_valid, hr[(c + 63) % 64]);
      p    = (c - D + 64) % 64;
      e_wr = hr[p];
      chk("wr_en", wr_en, e_wr);
      if (e_wr != 0) begin
        chk("wr_a", wr_addr_a, ha[p]);
        chk("wr_b", wr_addr_b, hb[p]);
      end
      chk("busy", busy, (done_cyc < 0 || c <= done_cyc) ? 1 : 0);
      chk("done", done, (c == done_cyc) ? 1 : 0);
      if (c == done_cyc) chk("final_sel", src_sel, LOGN % 2);
      if (done) begin n_done++; obs_done = c; end
      hr[c % 64] = e_rd;
      ha[c % 64] = (e_rd != 0) ? ea[ri-1] : 0;
      hb[c % 64] = (e_rd != 0) ? eb[ri-1] : 0;
      if (done_cyc >= 0 && c == done_cyc + 1) begin
        start = 1'b0;
        hold  = 1'b0;
        return;
      end
      h = ($urandom_range(99) < hold_pct) || (c < 64 && hmask[c]);
      hold  = h;
      hprev = h ? 1 : 0;
      start = (ri < TOT) && ($urandom_range(99) < start_pct);
      @(posedge clk); #1;
    end
    chk("timeout", 0, 1);
    start = 1'b0;
    hold  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    hold  = 1'b0;
    t     = 0;
    build_ref();
    repeat (2) @(posedge clk);
    #1 chk_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_zero("idle");

    run_xfer(0, 0, 64'h0, -1);
    chk("done_at_plain", obs_done, 25);
    chk("done_cnt_plain", n_done, 1);

    run_xfer(0, 0, 64'h1C00, -1);
    chk("done_at_hold_run", obs_done, 28);

    run_xfer(0, 0, 64'hE0, -1);
    chk("done_at_hold_drain", obs_done, 25);

    run_xfer(0, 50, 64'h0, -1);
    chk("done_at_restart", obs_done, 25);
    chk("done_cnt_restart", n_done, 1);

    run_xfer(0, 0, 64'h0, 13);
    run_xfer(0, 0, 64'h0, -1);
    chk("done_at_post_rst", obs_done, 25);

    for (int r = 0; r < 8; r++) begin
      run_xfer(25, 20, 64'h0, -1);
      chk("done_cnt_rand", n_done, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
